hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the five-stage MIPS core. Drives the

---
 rtl/hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forward sequencing with debug halt drain
// Redirects beat load-use stalls in every state; halt drains the pipe with ID bubbles.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CW           = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    rs_s2,
    input  logic [4:0]    rt_s2,
    input  logic [4:0]    rs_s3,
    input  logic [4:0]    rt_s3,
    input  logic          memread_s3,
    input  logic          regwrite_s4,
    input  logic [4:0]    wrreg_s4,
    input  logic          regwrite_s5,
    input  logic [4:0]    wrreg_s5,
    input  logic          pcsrc,
    input  logic          jump_s4,
    input  logic          halt_req,
    input  logic          cnt_clr,
    output logic          stall_s1_s2,
    output logic          pc_hold,
    output logic          flush_s1,
    output logic          flush_s2,
    output logic          flush_s3,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          halt_ack,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    logic       redirect;
    logic       loaduse;
    logic       stall_int;
    logic       pc_hold_int;
    logic       flush_s1_int;
    logic       flush_s23_int;
    logic [1:0] fwd_a_int;
    logic [1:0] fwd_b_int;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       rw4,
        input logic [4:0] wr4,
        input logic       rw5,
        input logic [4:0] wr5
    );
        if (rw4 && (wr4 != 5'd0) && (wr4 == src)) begin
            return 2'b10;
        end else if (rw5 && (wr5 != 5'd0) && (wr5 == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        redirect      = pcsrc | jump_s4;
        loaduse       = memread_s3 && (rt_s3 != 5'd0) &&
                        ((rt_s3 == rs_s2) || (rt_s3 == rt_s2));
        stall_int     = 1'b0;
        pc_hold_int   = 1'b0;
        flush_s1_int  = 1'b0;
        flush_s23_int = 1'b0;
        state_d       = state_q;
        dcnt_d        = dcnt_q;

        if (redirect) begin
            flush_s1_int  = 1'b1;
            flush_s23_int = 1'b1;
        end else begin
            stall_int = loaduse;
            // Outside RUN the PC is frozen; a load-use stall replaces the ID bubble.
            if (state_q != ST_RUN) begin
                pc_hold_int  = 1'b1;
                flush_s1_int = !loaduse;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (halt_req && !redirect) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (redirect) begin
                    dcnt_d = DRAIN_LOAD;
                end else if (loaduse) begin
                    dcnt_d = dcnt_q;
                end else if (dcnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        fwd_a_int = fwd_sel(rs_s3, regwrite_s4, wrreg_s4, regwrite_s5, wrreg_s5);
        fwd_b_int = fwd_sel(rt_s3, regwrite_s4, wrreg_s4, regwrite_s5, wrreg_s5);

        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            stall_cnt_d = (stall_int && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
            flush_cnt_d = (redirect && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
        end
    end

    always_comb begin
        stall_s1_s2 = 1'b0;
        pc_hold     = 1'b0;
        flush_s1    = 1'b0;
        flush_s2    = 1'b0;
        flush_s3    = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (rst_n) begin
            stall_s1_s2 = stall_int;
            pc_hold     = pc_hold_int;
            flush_s1    = flush_s1_int;
            flush_s2    = flush_s23_int;
            flush_s3    = flush_s23_int;
            fwd_a       = fwd_a_int;
            fwd_b       = fwd_b_int;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            dcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halt_ack  = (state_q == ST_HALTED);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and random checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int DRAIN = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_s2, rt_s2, rs_s3, rt_s3, wrreg_s4, wrreg_s5;
    logic       memread_s3, regwrite_s4, regwrite_s5, pcsrc, jump_s4, halt_req, cnt_clr;

    logic        stall_s1_s2, pc_hold, flush_s1, flush_s2, flush_s3, halt_ack;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall, s_ph, s_f1, s_f2, s_f3, s_ack;
    logic [1:0]  s_fa, s_fb, s_sc, s_fc;

    int checks = 0;
    int errors = 0;

    int m_mode, m_rem, m_sc, m_fc, m_sc2, m_fc2;
    logic m_red, m_lu;
    logic e_stall, e_ph, e_f1, e_f23, e_ack;
    logic [1:0] e_fa, e_fb;

    always #5 clk = ~clk;

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .rs_s2(rs_s2), .rt_s2(rt_s2), .rs_s3(rs_s3), .rt_s3(rt_s3),
        .memread_s3(memread_s3), .regwrite_s4(regwrite_s4), .wrreg_s4(wrreg_s4),
        .regwrite_s5(regwrite_s5), .wrreg_s5(wrreg_s5), .pcsrc(pcsrc), .jump_s4(jump_s4),
        .halt_req(halt_req), .cnt_clr(cnt_clr), .stall_s1_s2(stall_s1_s2), .pc_hold(pc_hold),
        .flush_s1(flush_s1), .flush_s2(flush_s2), .flush_s3(flush_s3), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .halt_ack(halt_ack), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CW(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .rs_s2(rs_s2), .rt_s2(rt_s2), .rs_s3(rs_s3), .rt_s3(rt_s3),
        .memread_s3(memread_s3), .regwrite_s4(regwrite_s4), .wrreg_s4(wrreg_s4),
        .regwrite_s5(regwrite_s5), .wrreg_s5(wrreg_s5), .pcsrc(pcsrc), .jump_s4(jump_s4),
        .halt_req(halt_req), .cnt_clr(cnt_clr), .stall_s1_s2(s_stall), .pc_hold(s_ph),
        .flush_s1(s_f1), .flush_s2(s_f2), .flush_s3(s_f3), .fwd_a(s_fa),
        .fwd_b(s_fb), .halt_ack(s_ack), .stall_cnt(s_sc), .flush_cnt(s_fc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (regwrite_s4 && wrreg_s4 != 0 && wrreg_s4 == src) return 2'b10;
        if (regwrite_s5 && wrreg_s5 != 0 && wrreg_s5 == src) return 2'b01;
        return 2'b00;
    endfunction

    // Modes: 0 running, 1 draining (m_rem bubbles still owed), 2 halted.
    task automatic model_eval();
        if (!rst_n) model_reset();
        m_red = pcsrc || jump_s4;
        m_lu  = memread_s3 && rt_s3 != 0 && (rt_s3 == rs_s2 || rt_s3 == rt_s2);
        e_ack = (m_mode == 2);
        if (m_red) begin
            e_stall = 0; e_ph = 0; e_f1 = 1; e_f23 = 1;
        end else begin
            e_stall = m_lu; e_ph = (m_mode != 0); e_f1 = (m_mode != 0) && !m_lu; e_f23 = 0;
        end
        e_fa = ref_fwd(rs_s3);
        e_fb = ref_fwd(rt_s3);
        if (!rst_n) begin
            e_stall = 0; e_ph = 0; e_f1 = 0; e_f23 = 0; e_fa = 0; e_fb = 0;
        end
    endtask

    task automatic settle();
        #4;
        model_eval();
        check("stall", stall_s1_s2, e_stall);
        check("pc_hold", pc_hold, e_ph);
        check("flush_s1", flush_s1, e_f1);
        check("flush_s2", flush_s2, e_f23);
        check("flush_s3", flush_s3, e_f23);
        check("fwd_a", fwd_a, e_fa);
        check("fwd_b", fwd_b, e_fb);
        check("halt_ack", halt_ack, e_ack);
        check("stall_cnt", stall_cnt, m_sc);
        check("flush_cnt", flush_cnt, m_fc);
        check("sat_outs", {s_stall, s_ph, s_f1, s_f2, s_f3, s_fa, s_fb, s_ack},
              {e_stall, e_ph, e_f1, e_f23, e_f23, e_fa, e_fb, e_ack});
        check("sat_stall_cnt", s_sc, m_sc2);
        check("sat_flush_cnt", s_fc, m_fc2);
    endtask

    task automatic adv();
        model_eval();
        if (rst_n) begin
            if (cnt_clr) begin
                m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
            end else begin
                if (e_stall) begin
                    m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc;
                    m_sc2 = (m_sc2 < 3) ? m_sc2 + 1 : m_sc2;
                end
                if (m_red) begin
                    m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
                    m_fc2 = (m_fc2 < 3) ? m_fc2 + 1 : m_fc2;
                end
            end
            case (m_mode)
                0: if (halt_req && !m_red) begin m_mode = 1; m_rem = DRAIN - 1; end
                1: begin
                    if (!halt_req) m_mode = 0;
                    else if (m_red) m_rem = DRAIN - 1;
                    else if (m_lu) m_rem = m_rem;
                    else if (m_rem == 0) m_mode = 2;
                    else m_rem = m_rem - 1;
                end
                default: if (!halt_req) m_mode = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rs_s2 = 0; rt_s2 = 0; rs_s3 = 0; rt_s3 = 0; wrreg_s4 = 0; wrreg_s5 = 0;
        memread_s3 = 0; regwrite_s4 = 0; regwrite_s5 = 0; pcsrc = 0; jump_s4 = 0;
        halt_req = 0; cnt_clr = 0;
    endtask

    initial begin
        rst_n = 0;
        clr_in();
        model_reset();
        @(posedge clk);
        #1;
        regwrite_s4 = 1; wrreg_s4 = 3; rs_s3 = 3; pcsrc = 1;
        settle();
        check("rst_fwd_a", fwd_a, 2'b00);
        check("rst_flush_s1", flush_s1, 1'b0);
        clr_in();
        adv();
        rst_n = 1;

        // lw $2 ; add $3,$2,$4
        memread_s3 = 1; rt_s3 = 2; rs_s2 = 2; rt_s2 = 4;
        settle();
        check("t1_stall", stall_s1_s2, 1'b1);
        adv();
        clr_in(); rs_s3 = 2; rt_s3 = 4; regwrite_s5 = 1; wrreg_s5 = 2;
        settle();
        check("t1_fwd_a_wb", fwd_a, 2'b01);
        check("t1_no_stall", stall_s1_s2, 1'b0);
        adv();
        check("t1_stall_cnt", stall_cnt, 16'd1);

        // add $5 ; sub $6,$5,$5
        clr_in(); regwrite_s4 = 1; wrreg_s4 = 5; rs_s3 = 5; rt_s3 = 5;
        regwrite_s5 = 1; wrreg_s5 = 5;
        settle();
        check("t2_fwd_a_mem", fwd_a, 2'b10);
        check("t2_fwd_b_mem", fwd_b, 2'b10);
        adv();
        regwrite_s4 = 0;
        settle();
        check("t2_fwd_b_wb", fwd_b, 2'b01);
        adv();
        clr_in(); regwrite_s4 = 1; wrreg_s4 = 0; rs_s3 = 0; regwrite_s5 = 1; wrreg_s5 = 0;
        settle();
        check("t2_r0_fwd", fwd_a, 2'b00);
        adv();

        // taken branch, then branch colliding with a load-use
        clr_in(); pcsrc = 1;
        settle();
        check("t3_flush_s3", flush_s3, 1'b1);
        adv();
        check("t3_flush_cnt", flush_cnt, 16'd1);
        memread_s3 = 1; rt_s3 = 9; rt_s2 = 9;
        settle();
        check("t3_redirect_beats_stall", stall_s1_s2, 1'b0);
        adv();
        clr_in(); cnt_clr = 1; pcsrc = 1;
        adv();
        check("t3_clr_flush", flush_cnt, 16'd0);
        check("t3_clr_stall", stall_cnt, 16'd0);

        // halt drain and release
        clr_in(); halt_req = 1;
        adv();
        settle();
        check("t4_pc_hold", pc_hold, 1'b1);
        for (int i = 1; i <= DRAIN; i++) begin
            adv();
            check("t4_ack_timing", halt_ack, (i == DRAIN) ? 1'b1 : 1'b0);
        end
        halt_req = 0;
        settle();
        adv();
        check("t4_ack_fall", halt_ack, 1'b0);
        settle();

        // jump during drain restarts the bubble count
        halt_req = 1;
        adv();
        adv();
        jump_s4 = 1;
        settle();
        check("t5_jump_pc_hold", pc_hold, 1'b0);
        check("t5_jump_flush_s2", flush_s2, 1'b1);
        adv();
        jump_s4 = 0;
        for (int i = 1; i <= DRAIN; i++) begin
            adv();
            check("t5_ack_timing", halt_ack, (i == DRAIN) ? 1'b1 : 1'b0);
        end
        halt_req = 0;
        adv();
        halt_req = 1;
        adv();
        adv();
        halt_req = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            adv();
        end
        check("t5_abort_no_ack", halt_ack, 1'b0);

        // async reset mid-drain, then counter saturation
        halt_req = 1;
        adv();
        memread_s3 = 1; rt_s3 = 7; rs_s2 = 7;
        settle();
        adv();
        regwrite_s4 = 1; wrreg_s4 = 8; rs_s3 = 8;
        rst_n = 0;
        #1;
        check("t6_rst_pc_hold", pc_hold, 1'b0);
        check("t6_rst_stall", stall_s1_s2, 1'b0);
        check("t6_rst_fwd", fwd_a, 2'b00);
        check("t6_rst_stall_cnt", stall_cnt, 16'd0);
        settle();
        adv();
        rst_n = 1;
        clr_in();
        memread_s3 = 1; rt_s3 = 7; rs_s2 = 7;
        for (int i = 0; i < 5; i++) begin
            settle();
            adv();
        end
        check("t6_sat_cnt", s_sc, 2'd3);
        check("t6_wide_cnt", stall_cnt, 16'd5);

        clr_in();
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 599) != 0);
            rs_s2       = 5'($urandom_range(0, 3));
            rt_s2       = 5'($urandom_range(0, 3));
            rs_s3       = 5'($urandom_range(0, 3));
            rt_s3       = 5'($urandom_range(0, 3));
            wrreg_s4    = 5'($urandom_range(0, 3));
            wrreg_s5    = 5'($urandom_range(0, 3));
            memread_s3  = ($urandom_range(0, 2) == 0);
            regwrite_s4 = 1'($urandom_range(0, 1));
            regwrite_s5 = 1'($urandom_range(0, 1));
            pcsrc       = ($urandom_range(0, 9) == 0);
            jump_s4     = ($urandom_range(0, 14) == 0);
            cnt_clr     = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
            settle();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
